// File: rtl/simon_axil_csr.sv
// AXI4-Lite CSR block for the Simon cipher core: NUM_REGS 32-bit registers with
// per-register RW / hardware-owned RO / self-clearing pulse modes, byte-lane merge,
// independent AW/W buffering, and SLVERR on illegal or read-only accesses.
module simon_axil_csr #(
  parameter int unsigned                      ADDR_WIDTH  = 40,
  parameter int unsigned                      DATA_WIDTH  = 32,
  parameter int unsigned                      NUM_REGS    = 18,
  parameter logic [ADDR_WIDTH-1:0]            BASE_ADDR   = 40'h4c300000,
  parameter logic [NUM_REGS-1:0]              RO_MASK     = 18'h3e000,
  parameter logic [NUM_REGS-1:0]              PULSE_MASK  = 18'h01000,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                             aclk,
  input  logic                             arst_n,
  // write address
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic [2:0]                       awprot,
  // write data
  input  logic                             wvalid,
  output logic                             wready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  // write response
  output logic                             bvalid,
  input  logic                             bready,
  output logic [1:0]                       bresp,
  // read address
  input  logic                             arvalid,
  output logic                             arready,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic [2:0]                       arprot,
  // read data
  output logic                             rvalid,
  input  logic                             rready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  // register-file side
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]              wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_d,
  input  logic [NUM_REGS-1:0]              hw_we
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hdeadbeef);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Protection bits carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // Offset decode: unsigned wrap makes addresses below BASE_ADDR fail the range test.
  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (off < SPAN) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  // Register storage
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Write-path state
  wstate_t                 wstate_q, wstate_d;
  logic                    aw_full_q, aw_full_d;
  logic                    w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic                    aw_hs, w_hs;
  logic                    awready_d, wready_d, bvalid_d;
  logic [1:0]              bresp_d;
  logic [NUM_REGS-1:0]     wsel, wr_commit;
  logic                    wr_ok;

  // Read-path state
  rstate_t                 rstate_q, rstate_d;
  logic                    ar_hs;
  logic                    arready_d, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_d, rd_val;
  logic [1:0]              rresp_d;
  logic [NUM_REGS-1:0]     rsel;
  logic                    rd_legal;

  // Flatten storage onto the reg_q bus
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Write target decode from the buffered address
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel[i] = addr_legal(aw_addr_q) && (addr_index(aw_addr_q) == IDX_W'(i));
    end
    wr_ok = |(wsel & ~RO_MASK);
  end

  // Write FSM next-state and registered-output next values
  always_comb begin
    wstate_d  = wstate_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    wr_commit = '0;
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    if (aw_hs) aw_full_d = 1'b1;
    if (w_hs)  w_full_d  = 1'b1;
    case (wstate_q)
      W_IDLE: begin
        if (aw_full_d && w_full_d) wstate_d = W_EXEC;
      end
      W_EXEC: begin
        wr_commit = wsel & ~RO_MASK;
        bvalid_d  = 1'b1;
        bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        wstate_d  = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = !aw_full_d && (wstate_d == W_IDLE);
    wready_d  = !w_full_d  && (wstate_d == W_IDLE);
  end

  // Write-path registers
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      wstate_q  <= W_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      awready   <= awready_d;
      wready    <= wready_d;
      bvalid    <= bvalid_d;
      bresp     <= bresp_d;
      wr_pulse  <= wr_commit;
    end
  end

  // Register next values: pulse revert, then hardware load, then bus write (bus wins)
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = PULSE_MASK[i] ? RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      if (hw_we[i]) regs_d[i] = hw_d[i*DATA_WIDTH +: DATA_WIDTH];
      if (wr_commit[i]) begin
        for (int k = 0; k < STRB_W; k++) begin
          regs_d[i][k*8 +: 8] = w_strb_q[k] ? w_data_q[k*8 +: 8] : regs_q[i][k*8 +: 8];
        end
      end
    end
  end

  // Register storage update
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read decode and data select; pulse registers read back their reset value
  always_comb begin
    rsel     = '0;
    rd_val   = '0;
    rd_legal = addr_legal(araddr);
    for (int i = 0; i < NUM_REGS; i++) begin
      rsel[i] = rd_legal && (addr_index(araddr) == IDX_W'(i));
      if (rsel[i]) begin
        rd_val = PULSE_MASK[i] ? RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  // Read FSM next-state and registered-output next values
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid;
    rdata_d  = rdata;
    rresp_d  = rresp;
    ar_hs    = arvalid && arready;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_legal ? rd_val : BAD_DATA;
          rresp_d  = rd_legal ? RESP_OKAY : RESP_SLVERR;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Read-path registers
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      rstate_q <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      arready  <= arready_d;
      rvalid   <= rvalid_d;
      rdata    <= rdata_d;
      rresp    <= rresp_d;
    end
  end

endmodule

// File: doc/simon_axil_csr.md
# simon_axil_csr

Parametrised AXI4-Lite control/status register block for the Simon cipher core, sitting between the system interconnect and the cipher datapath. It provides NUM_REGS 32-bit registers at word-aligned offsets from BASE_ADDR. Each register has a per-register access mode: read/write, hardware-owned read-only, or self-clearing write pulse. Unlike the first-generation register file, it does byte-lane merging on writes, accepts AW and W independently, and returns SLVERR on illegal accesses.

## Interface
- ADDR_WIDTH, 40, AXI address width
- DATA_WIDTH, 32, data width; only 32 is supported
- NUM_REGS, 18, number of registers (1..256)
- BASE_ADDR, 40'h4c300000, byte address of register 0; must be aligned to 4*NUM_REGS rounded up to a power of 2
- RO_MASK, 18'h3e000, bit i=1: register i is hardware-owned and read-only from the bus (default covers done and out_data_0..3 at indices 13..17)
- PULSE_MASK, 18'h01000, bit i=1: register i is a write-pulse register (default covers start at index 12); must not overlap RO_MASK
- RESET_VALUE, {NUM_REGS*32{1'b0}}, flat reset image; register i occupies bits [32i+31:32i]

Ports:
- aclk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- awvalid/awready  in/out  1  write-address handshake
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  ignored
- wvalid/wready  in/out  1  write-data handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- bvalid/bready  out/in  1  write-response handshake
- bresp  out  2  write response: 00 OKAY, 10 SLVERR
- arvalid/arready  in/out  1  read-address handshake
- araddr  in  ADDR_WIDTH  read address
- arprot  in  3  ignored
- rvalid/rready  out/in  1  read-data handshake
- rdata  out  32  read data
- rresp  out  2  read response
- reg_q  out  NUM_REGS*32  current register values
- wr_pulse  out  NUM_REGS  one-cycle strobe: register i was written by the bus with OKAY
- hw_d  in  NUM_REGS*32  hardware update data
- hw_we  in  NUM_REGS  hardware update enable, one bit per register

## Operation
- Decode: offset = addr − BASE_ADDR. The access is legal if 0 ≤ offset < 4*NUM_REGS and addr[1:0]==0. Index = offset>>2.
- Write path: one-deep AW buffer and one-deep W buffer, filled independently in either order or in the same cycle. The write executes once both buffers are full.
- RW write: reg[i] byte k = wstrb[k] ? wdata byte k : old byte k. Response OKAY. wr_pulse[i]=1 for one cycle.
- PULSE write: reg_q bits take the merged value for exactly one cycle, then return to RESET_VALUE. Reads of a pulse register return RESET_VALUE. Response OKAY. wr_pulse[i]=1.
- RO write, illegal address or misaligned address: no register changes, no wr_pulse, bresp=SLVERR.
- Hardware update: hw_we[i]=1 loads hw_d slice i into reg[i] on that edge, for any mode. If a bus write to an RW or PULSE register coincides with hw_we on the same register, the bus write wins.
- Write FSM states:
  - W_IDLE: wait for both buffers full.
  - W_EXEC: apply the write and assert bvalid.
  - W_RESP: hold bvalid until bready; return to W_IDLE on the b handshake.
- Read FSM states:
  - R_IDLE (arready=1): on ar handshake, latch rdata/rresp → R_DATA.
  - R_DATA: rvalid=1; return to R_IDLE on the r handshake.
- Read data: reg[i], or RESET_VALUE slice for a pulse register. An illegal address returns 32'hdeadbeef with rresp=SLVERR.
- The read and write paths are fully independent; a read and a write may complete in the same cycle.

## Timing
- Reset values, held while arst_n=0 and valid on the first edge after release:
  - awready, wready, arready, bvalid, rvalid = 0
  - bresp, rresp = 00
  - rdata = 0
  - reg_q = RESET_VALUE
  - wr_pulse = 0
  - both buffers empty
- Readies rise in the first cycle after reset release.
- awready = AW buffer empty and write FSM not in W_EXEC/W_RESP. wready is defined the same way for the W buffer. A buffer drops its ready the cycle after its handshake.
- Write latency: last of AW/W captured at edge E. At edge E+1 the register is updated, bvalid=1, and wr_pulse=1 for that cycle only. awready and wready rise the cycle after the b handshake.
- Pulse register: the merged value is visible on reg_q for the single cycle after edge E+1, then reverts.
- Read latency: ar handshake at edge E. rvalid and rdata are valid after E. rdata reflects register state as of edge E and does not include a write executing at E. arready rises the cycle after the r handshake.
- bvalid, bresp, rvalid, rdata and rresp stay stable until their handshake completes.
- Reset mid-transaction: all in-flight transactions are discarded without a response, and every output returns to its reset value.

## Test plan
- AW then W two cycles later: addr 0x4c300004, wdata 0x12345678, wstrb 0xf → inp_data_1 = 0x12345678, bresp 00. Read back gives 0x12345678, rresp 00.
- Partial strobe: reg 0 = 0xaabbccdd, then write 0x11223344 with wstrb 0x5 → reg 0 = 0xaa22cc44.
- Pulse: write 0x1 to 0x4c300030 → reg_q start bit is 1 for exactly one cycle, then 0; wr_pulse[12] is 1 for one cycle. Readback gives 0.
- RO and illegal access:
  - Write to 0x4c300034 (done) → SLVERR, value unchanged.
  - Read 0x4c300048 → 0xdeadbeef with SLVERR.
  - Read 0x4c300002 → SLVERR.
- Hardware update: hw_we[14]=1 with hw_d slice 0xcafef00d → read 0x4c300038 gives 0xcafef00d. A same-cycle bus write and hw_we on RW reg 0 → the bus value is stored.
- Back-pressure and reset:
  - Hold bready=0 for 5 cycles → bvalid stays 1 and awready stays 0.
  - Assert arst_n=0 while rvalid=1 → rvalid=0 and all registers return to RESET_VALUE.
